// File: rtl/xbus_slave_mem.sv
// XBUS slave memory: 2^ADDR_BITS x 32-bit words with WAIT wait states and byte-enabled writes.
// Optional macro XBUS_ERR_EN adds XERR for accesses above the implemented address range.
module xbus_slave_mem #(
  parameter int ADDR_BITS = 10,
  parameter int WAIT      = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        XDREQ,
  input  logic        XWR,
  input  logic        XRD,
  input  logic [3:0]  XBE,
  input  logic [31:0] XADDR,
  input  logic [31:0] XDATAI,
  output logic [31:0] XDATAO,
  output logic        XDACK,
`ifdef XBUS_ERR_EN
  output logic        XERR,
`endif
  output logic [3:0]  DEBUG
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_dack;
  logic        r_commit;
  logic        r_err;
  logic [31:0] r_datao;

  logic        r_wr;
  logic        r_rd;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  logic [31:0] r_mem [0:(2**ADDR_BITS)-1];

  logic                 w_accept;
  logic                 w_enter_ack;
  logic                 w_sel_in;
  logic                 w_wr;
  logic                 w_rd;
  logic [3:0]           w_be;
  logic [31:0]          w_addr;
  logic [31:0]          w_data;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_oor;
  logic                 w_commit;
  logic                 w_re;
  logic                 w_unused_addr;

  assign w_accept    = (r_state == S_IDLE) && XDREQ;
  assign w_enter_ack = (w_accept && (WAIT == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With no wait states ACK is entered on the accept edge itself, so the live bus fields apply.
  assign w_sel_in = (r_state == S_IDLE);
  assign w_wr     = w_sel_in ? XWR    : r_wr;
  assign w_rd     = w_sel_in ? XRD    : r_rd;
  assign w_be     = w_sel_in ? XBE    : r_be;
  assign w_addr   = w_sel_in ? XADDR  : r_addr;
  assign w_data   = w_sel_in ? XDATAI : r_data;
  assign w_idx    = w_addr[ADDR_BITS+1:2];

`ifdef XBUS_ERR_EN
  localparam logic [31:0] HI_MASK = ~((32'd1 << (ADDR_BITS + 2)) - 32'd1);
  assign w_oor = |(w_addr & HI_MASK);
`else
  assign w_oor = 1'b0;
`endif

  assign w_commit      = w_enter_ack && w_wr && !w_oor && (|w_be);
  assign w_re          = w_rd && !w_wr;
  assign w_unused_addr = ^r_addr;

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_dack   <= 1'b0;
      r_commit <= 1'b0;
      r_err    <= 1'b0;
      r_datao  <= 32'h0;
    end else begin
      r_dack   <= 1'b0;
      r_commit <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (XDREQ) begin
            r_wr   <= XWR;
            r_rd   <= XRD;
            r_be   <= XBE;
            r_addr <= XADDR;
            r_data <= XDATAI;
            if (WAIT > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT - 1);
            end else begin
              r_state <= S_ACK;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_ACK;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_enter_ack) begin
        r_dack   <= 1'b1;
        r_commit <= w_commit;
        r_err    <= w_oor;
        if (w_re) r_datao <= w_oor ? 32'hFFFF_FFFF : r_mem[w_idx];
      end
    end
  end

  // Memory has no reset; a reset edge also blocks the commit of a pending write.
  always_ff @(posedge CLK) begin
    if (!RES && w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  assign XDATAO = r_datao;
  assign XDACK  = r_dack;
  assign DEBUG  = {r_state, r_dack, r_commit};
`ifdef XBUS_ERR_EN
  assign XERR   = r_err;
`else
  logic w_unused_err;
  assign w_unused_err = r_err;
`endif

endmodule

// File: doc/xbus_slave_mem.md
XBUS_SLAVE_MEM -- requirements
Module: xbus_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, giving the word-address width (2^ADDR_BITS 32-bit words).
REQ-002 SHALL have parameter WAIT, default 1, range 0..15, giving the wait states inserted before acknowledge.
REQ-003 CLK  in  1  clock; all logic on the rising edge; one clock only.
REQ-004 RES  in  1  reset, synchronous and active-high.
REQ-005 XDREQ  in  1  request valid; held by the initiator until it samples XDACK high.
REQ-006 XWR  in  1  write strobe.
REQ-007 XRD  in  1  read strobe.
REQ-008 XBE  in  4  byte enables; bit n selects data bits [8n+7:8n].
REQ-009 XADDR  in  32  byte address.
REQ-010 XDATAI  in  32  write data.
REQ-011 XDATAO  out  32  read data; registered.
REQ-012 XDACK  out  1  one-cycle acknowledge pulse; registered.
REQ-013 DEBUG  out  4  {state[1:0], XDACK, write-commit pulse}.

Function
REQ-014 SHALL implement the states IDLE, WAIT and ACK.
REQ-015 IDLE: XDREQ=1 at an edge SHALL latch XWR, XRD, XBE, XADDR and XDATAI, and SHALL go to WAIT when WAIT>0, otherwise to ACK.
REQ-016 WAIT: a counter loaded with WAIT-1 on accept SHALL decrement each cycle; at zero the block SHALL go to ACK.
REQ-017 ACK: XDACK=1 for exactly one cycle, then IDLE; XDACK SHALL be high in cycle N+1+WAIT for a request accepted at edge N.
REQ-018 Inputs SHALL be ignored outside IDLE; latched fields govern the transaction.
REQ-019 Word index SHALL be latched XADDR[ADDR_BITS+1:2]; XADDR[1:0] SHALL be ignored.
REQ-020 Write (latched XWR=1): the write SHALL commit only the enabled bytes, on the edge entering ACK; XDATAO SHALL be unchanged.
REQ-021 Read (XRD=1, XWR=0): XDATAO SHALL present the full addressed word during the ACK cycle and hold it until the next read ACK.
REQ-022 XWR and XRD both high SHALL be treated as a write.
REQ-023 XDREQ with neither strobe, or a write with XBE=0, SHALL be acknowledged with no memory or XDATAO change.
REQ-024 XDREQ still high in IDLE after an ACK SHALL be accepted as a new transaction (back-to-back is legal; minimum spacing is one IDLE cycle).
REQ-025 XDREQ deasserted during WAIT SHALL NOT abort; the transaction completes and acknowledges.
REQ-026 With ADDR_BITS unconstrained by XBUS_ERR_EN, address bits above ADDR_BITS+1 SHALL be ignored (aliasing).

Reset
REQ-027 RES=1 SHALL force IDLE, counter=0, XDACK=0, XDATAO=32'h0 and DEBUG=0 at the next edge.
REQ-028 Reset during WAIT SHALL cancel the transaction with no memory write and no acknowledge.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 The macro XBUS_ERR_EN, when defined, SHALL add output XERR (1 bit, reset 0), asserted only together with XDACK.
REQ-031 With XBUS_ERR_EN, any nonzero latched XADDR bit above ADDR_BITS+1 SHALL raise XERR and suppress the memory write.
REQ-032 With XBUS_ERR_EN, such an out-of-range read SHALL return XDATAO=32'hFFFFFFFF; timing is unchanged.
REQ-033 Without XBUS_ERR_EN, XERR SHALL be absent and REQ-026 aliasing SHALL apply.

Verification
REQ-034 WAIT=0: write 32'hDEADBEEF to 0x10 with XBE=4'hF, then read 0x10 -> each XDACK one cycle after accept; read returns 32'hDEADBEEF.
REQ-035 WAIT=3: read accepted at edge N -> XDACK high only in cycle N+4; XDREQ dropped at N+2 still yields the XDACK.
REQ-036 Preload 32'h11223344 at 0x20; write 32'hAABBCCDD with XBE=4'b0101 -> read returns 32'h11BB33DD.
REQ-037 Back-to-back: XDREQ held high across write then read of 0x40 -> two XDACK pulses separated by one IDLE cycle; read returns the written data.
REQ-038 RES asserted during WAIT of a write to 0x30 (old value 32'h5) -> no XDACK; subsequent read returns 32'h5.
REQ-039 XBUS_ERR_EN, ADDR_BITS=10: read 0x00001000 -> XDACK=1, XERR=1, XDATAO=32'hFFFFFFFF; write there leaves word 0 unchanged.
